// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush sequencing for the 5-stage MIPS core.
// PERF_CNT_EN adds stall/flush performance counters; without it both counter ports read 0.
module hazard_ctrl #(
  parameter int DWAIT_MAX = 255,
  parameter int CNT_W     = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dren,
  input  logic             mem_dwen,
  input  logic             mem_halt,
  input  logic             idex_dren,
  input  logic [4:0]       idex_rt,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ex_redirect,
  output logic             pc_wen,
  output logic             ifid_wen,
  output logic             ifid_flush,
  output logic             idex_wen,
  output logic             idex_flush,
  output logic             exmem_wen,
  output logic             memwb_wen,
  output logic             halt,
  output logic             dmem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DWAIT = 2'd1;
  localparam logic [1:0] HALT  = 2'd2;
  localparam logic [7:0] WMAX  = 8'(DWAIT_MAX);
  logic [1:0] state_q, state_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic       halt_q, halt_d, tout_q, tout_d;
  logic       run, dpend, luse, adv;
  always_comb begin
    run        = nRST && state_q != HALT;
    dpend      = (mem_dren || mem_dwen) && !dhit;
    luse       = idex_dren && idex_rt != 5'd0 && (idex_rt == ifid_rs || idex_rt == ifid_rt);
    adv        = run && !dpend;
    exmem_wen  = adv;
    memwb_wen  = adv;
    idex_wen   = adv;
    pc_wen     = adv && (ex_redirect || (!luse && ihit));
    ifid_wen   = adv && (ex_redirect || !luse);
    ifid_flush = adv && (ex_redirect || (!luse && !ihit));
    idex_flush = adv && (ex_redirect || luse);
    state_d    = state_q == HALT ? HALT : dpend ? DWAIT : mem_halt ? HALT : RUN;
    // Counts every pending data cycle, including the one that leaves RUN
    wcnt_d     = state_q == HALT ? wcnt_q : !dpend ? 8'd0 : wcnt_q == 8'hff ? wcnt_q : wcnt_q + 8'd1;
    tout_d     = tout_q || (run && dpend && wcnt_d == WMAX);
    halt_d     = state_d == HALT;
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      wcnt_q  <= '0;
      halt_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      halt_q  <= halt_d;
      tout_q  <= tout_d;
    end
  end
  assign halt         = halt_q;
  assign dmem_timeout = tout_q;
`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  always_comb begin
    stall_d = stall_q + {{(CNT_W-1){1'b0}}, run && !pc_wen};
    flush_d = flush_q + {{(CNT_W-1){1'b0}}, adv && ex_redirect};
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule
